// File: rtl/bus_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : bus_trace_monitor
// Purpose  : Records CPU bus transactions into a trace FIFO over a capture run that ends on abort, a full FIFO or the cycle limit.
// Options  : BUS_TRACE_TIMESTAMP_EN builds the timestamp register, which drives the ts field. Without it, ts reads 0.
// Revision : 1.0  initial release
// ============================================================================
module bus_trace_monitor #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 64,
  parameter int TS_W        = 20,
  parameter int CYCLE_LIMIT = 500000,
  parameter int WRAP        = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_W-1:0]                 ADDRBUS,
  input  logic [1:0]                        CTRLBUS,
  input  logic [DATA_W-1:0]                 DATABUS,
  input  logic                              arm,
  input  logic                              abort,
  input  logic                              rd_en,
  output logic                              rd_valid,
  output logic [TS_W+2+ADDR_W+DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              empty,
  output logic                              full,
  output logic                              overflow,
  output logic                              proto_err,
  output logic                              timeout,
  output logic                              done
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = TS_W + 2 + ADDR_W + DATA_W;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [31:0]   LIM_LAST = 32'(CYCLE_LIMIT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]          state;
  logic [31:0]         lim_cnt;
  logic [1:0]          prev_ctrl;
  logic [ADDR_W-1:0]   prev_addr;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic                pop_pend;
  logic [ENTRY_W-1:0]  pop_data;
  logic [TS_W-1:0]     ts_val;

  logic capturing;
  logic new_txn;
  logic push_req;
  logic pop;
  logic full_drop;
  logic push;
  logic displace;
  logic limit_hit;

`ifdef BUS_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt <= '0;
    end else if (arm) begin
      ts_cnt <= '0;
    end else if (capturing) begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  assign ts_val = ts_cnt;
`else
  assign ts_val = '0;
`endif

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign done      = (state == S_DONE);
  assign capturing = (state == S_CAPTURE);

  // A transaction starts on the first non-idle cycle or whenever ctrl/addr changes.
  assign new_txn   = (CTRLBUS != 2'b00) &&
                     ((prev_ctrl == 2'b00) || (CTRLBUS != prev_ctrl) || (ADDRBUS != prev_addr));
  assign push_req  = capturing && new_txn && !arm;
  assign pop       = rd_en && !empty && !arm;
  assign full_drop = push_req && full && !pop && (WRAP == 0);
  assign push      = push_req && !full_drop;
  assign displace  = push && full && !pop;
  assign limit_hit = (CYCLE_LIMIT != 0) && (lim_cnt == LIM_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_ctrl <= 2'b00;
      prev_addr <= '0;
    end else begin
      prev_ctrl <= CTRLBUS;
      prev_addr <= ADDRBUS;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      lim_cnt   <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      timeout   <= 1'b0;
    end else if (arm) begin
      state     <= S_CAPTURE;
      lim_cnt   <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      timeout   <= 1'b0;
    end else if (capturing) begin
      lim_cnt <= lim_cnt + 1'b1;
      if (CTRLBUS == 2'b11) proto_err <= 1'b1;
      if (full_drop || displace) overflow <= 1'b1;
      if (limit_hit) timeout <= 1'b1;
      if (abort || limit_hit || full_drop) state <= S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (arm) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // A wrap-mode overwrite retires the oldest entry in the same cycle.
      if (pop || displace) rd_ptr <= rd_ptr + 1'b1;
      case ({push && !displace, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ts_val, CTRLBUS, ADDRBUS, DATABUS};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_pend <= 1'b0;
      pop_data <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      pop_pend <= pop;
      if (pop) pop_data <= mem[rd_ptr];
      rd_valid <= pop_pend;
      if (pop_pend) rd_data <= pop_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_trace_monitor.sv
`default_nettype none
// Directed bench for bus_trace_monitor: stop-when-full and wrap instances sharing one bus.
module tb_bus_trace_monitor;

  localparam int EW = 54;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   addrbus = '0;
  logic [1:0]    ctrlbus = '0;
  logic [15:0]   databus = '0;

  logic          arm_a = 1'b0, abort_a = 1'b0, rd_en_a = 1'b0;
  logic          rd_valid_a, empty_a, full_a, overflow_a, proto_err_a, timeout_a, done_a;
  logic [EW-1:0] rd_data_a;
  logic [2:0]    count_a;

  logic          arm_b = 1'b0, abort_b = 1'b0, rd_en_b = 1'b0;
  logic          rd_valid_b, empty_b, full_b, overflow_b, proto_err_b, timeout_b, done_b;
  logic [EW-1:0] rd_data_b;
  logic [2:0]    count_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_trace_monitor #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .TS_W(20),
                      .CYCLE_LIMIT(100), .WRAP(0)) dut_a (
    .clk(clk), .reset(reset), .ADDRBUS(addrbus), .CTRLBUS(ctrlbus), .DATABUS(databus),
    .arm(arm_a), .abort(abort_a), .rd_en(rd_en_a), .rd_valid(rd_valid_a), .rd_data(rd_data_a),
    .count(count_a), .empty(empty_a), .full(full_a), .overflow(overflow_a),
    .proto_err(proto_err_a), .timeout(timeout_a), .done(done_a));

  bus_trace_monitor #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .TS_W(20),
                      .CYCLE_LIMIT(0), .WRAP(1)) dut_b (
    .clk(clk), .reset(reset), .ADDRBUS(addrbus), .CTRLBUS(ctrlbus), .DATABUS(databus),
    .arm(arm_b), .abort(abort_b), .rd_en(rd_en_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
    .count(count_b), .empty(empty_b), .full(full_b), .overflow(overflow_b),
    .proto_err(proto_err_b), .timeout(timeout_b), .done(done_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [1:0] c, input logic [15:0] a, input logic [15:0] d);
    ctrlbus = c;
    addrbus = a;
    databus = d;
  endtask

  task automatic pop_a(output logic v, output logic [EW-1:0] d);
    rd_en_a = 1'b1;
    tick();
    rd_en_a = 1'b0;
    tick();
    v = rd_valid_a;
    d = rd_data_a;
  endtask

  task automatic pop_b(output logic v, output logic [EW-1:0] d);
    rd_en_b = 1'b1;
    tick();
    rd_en_b = 1'b0;
    tick();
    v = rd_valid_b;
    d = rd_data_b;
  endtask

  task automatic arm_dut_a();
    arm_a = 1'b1;
    tick();
    arm_a = 1'b0;
  endtask

  // {rd_valid,count,empty,full,overflow,proto_err,timeout,done}
  task automatic test_reset();
    logic [9:0] obs;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    obs = {rd_valid_a, count_a, empty_a, full_a, overflow_a, proto_err_a, timeout_a, done_a};
    n_tests++;
    if (obs !== 10'b0_000_1_0_0_0_0_0) begin
      n_fail++;
      $display("FAIL reset_flags_a: got %b expected %b", obs, 10'b0000100000);
    end
    n_tests++;
    if (rd_data_a !== '0 || rd_data_b !== '0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h/%h expected 0", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_single_write();
    logic v;
    logic [EW-1:0] d;
    arm_dut_a();
    bus(2'b10, 16'h0100, 16'hBEEF);
    repeat (3) tick();
    bus(2'b00, 16'h0000, 16'h0000);
    tick();
    n_tests++;
    if (count_a !== 3'd1) begin
      n_fail++;
      $display("FAIL single_count: got %0d expected 1", count_a);
    end
    pop_a(v, d);
    n_tests++;
    if (v !== 1'b1 || d[33:0] !== {2'b10, 16'h0100, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL single_entry: valid %b data %h expected valid 1 ctrl/addr/data 2/0100/beef", v, d[33:0]);
    end
    tick();
    n_tests++;
    if (rd_valid_a !== 1'b0 || d !== rd_data_a) begin
      n_fail++;
      $display("FAIL single_pulse_hold: valid %b data %h expected valid 0 data %h", rd_valid_a, rd_data_a, d);
    end
  endtask

  task automatic test_full_stop();
    logic v;
    logic [EW-1:0] d;
    logic [4:0] obs;
    arm_dut_a();
    for (int i = 0; i < 5; i++) begin
      bus(2'b01, 16'(i), 16'(16'hA000 + i));
      tick();
    end
    bus(2'b00, 16'h0000, 16'h0000);
    tick();
    obs = {full_a, done_a, overflow_a, timeout_a, empty_a};
    n_tests++;
    if (obs !== 5'b11100 || count_a !== 3'd4) begin
      n_fail++;
      $display("FAIL full_stop_flags: got %b count %0d expected 11100 count 4", obs, count_a);
    end
    for (int i = 0; i < 4; i++) begin
      pop_a(v, d);
      n_tests++;
      if (v !== 1'b1 || d[31:0] !== {16'(i), 16'(16'hA000 + i)} || d[33:32] !== 2'b01) begin
        n_fail++;
        $display("FAIL full_stop_pop%0d: valid %b data %h expected addr %0d", i, v, d[33:0], i);
      end
    end
    n_tests++;
    if (empty_a !== 1'b1 || count_a !== 3'd0) begin
      n_fail++;
      $display("FAIL full_stop_empty: empty %b count %0d expected 1/0", empty_a, count_a);
    end
    pop_a(v, d);
    n_tests++;
    if (v !== 1'b0 || count_a !== 3'd0) begin
      n_fail++;
      $display("FAIL empty_pop: valid %b count %0d expected 0/0", v, count_a);
    end
  endtask

  task automatic test_wrap();
    logic v;
    logic [EW-1:0] d;
    arm_b = 1'b1;
    tick();
    arm_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus(2'b01, 16'(i), 16'(16'hB000 + i));
      tick();
    end
    bus(2'b00, 16'h0000, 16'h0000);
    tick();
    n_tests++;
    if (done_b !== 1'b0 || overflow_b !== 1'b1 || count_b !== 3'd4 || full_b !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_flags: done %b ovf %b count %0d full %b expected 0/1/4/1",
               done_b, overflow_b, count_b, full_b);
    end
    for (int i = 2; i < 6; i++) begin
      pop_b(v, d);
      n_tests++;
      if (v !== 1'b1 || d[31:16] !== 16'(i) || d[15:0] !== 16'(16'hB000 + i)) begin
        n_fail++;
        $display("FAIL wrap_pop%0d: valid %b data %h expected addr %0d", i, v, d[33:0], i);
      end
    end
  endtask

  task automatic test_cycle_limit();
    arm_dut_a();
    repeat (99) tick();
    n_tests++;
    if (done_a !== 1'b0 || timeout_a !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_early: done %b timeout %b expected 0/0 at 99 cycles", done_a, timeout_a);
    end
    tick();
    n_tests++;
    if (done_a !== 1'b1 || timeout_a !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_hit: done %b timeout %b expected 1/1 at 100 cycles", done_a, timeout_a);
    end
    arm_dut_a();
    n_tests++;
    if (done_a !== 1'b0 || timeout_a !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_rearm: done %b timeout %b expected 0/0", done_a, timeout_a);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    n_tests++;
    if (done_a !== 1'b1 || timeout_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: done %b timeout %b expected 1/0", done_a, timeout_a);
    end
    arm_a = 1'b1;
    abort_a = 1'b1;
    tick();
    arm_a = 1'b0;
    abort_a = 1'b0;
    n_tests++;
    if (done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_over_abort: done %b expected 0", done_a);
    end
  endtask

  task automatic test_proto_ts();
    logic v;
    logic [EW-1:0] d;
    logic [19:0] exp_ts;
`ifdef BUS_TRACE_TIMESTAMP_EN
    exp_ts = 20'd7;
`else
    exp_ts = 20'd0;
`endif
    arm_dut_a();
    repeat (7) tick();
    bus(2'b11, 16'h0055, 16'h1234);
    tick();
    bus(2'b00, 16'h0000, 16'h0000);
    tick();
    n_tests++;
    if (proto_err_a !== 1'b1 || count_a !== 3'd1) begin
      n_fail++;
      $display("FAIL proto_flag: proto_err %b count %0d expected 1/1", proto_err_a, count_a);
    end
    pop_a(v, d);
    n_tests++;
    if (v !== 1'b1 || d !== {exp_ts, 2'b11, 16'h0055, 16'h1234}) begin
      n_fail++;
      $display("FAIL proto_entry: valid %b data %h expected %h", v, d, {exp_ts, 2'b11, 16'h0055, 16'h1234});
    end
  endtask

  task automatic test_reset_midrun();
    logic v;
    logic [EW-1:0] d;
    logic [9:0] obs;
    arm_dut_a();
    bus(2'b01, 16'h0010, 16'h1111);
    tick();
    bus(2'b11, 16'h0011, 16'h2222);
    tick();
    bus(2'b10, 16'h0012, 16'h3333);
    tick();
    bus(2'b00, 16'h0000, 16'h0000);
    tick();
    n_tests++;
    if (count_a !== 3'd3 || proto_err_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_pre: count %0d proto_err %b expected 3/1", count_a, proto_err_a);
    end
    #2;
    reset = 1'b0;
    #1;
    obs = {rd_valid_a, count_a, empty_a, full_a, overflow_a, proto_err_a, timeout_a, done_a};
    n_tests++;
    if (obs !== 10'b0_000_1_0_0_0_0_0 || rd_data_a !== '0 || overflow_b !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_async_reset: flags %b rd_data %h ovf_b %b expected 0000100000/0/0",
               obs, rd_data_a, overflow_b);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    pop_a(v, d);
    n_tests++;
    if (v !== 1'b0 || count_a !== 3'd0) begin
      n_fail++;
      $display("FAIL midrun_pop: valid %b count %0d expected 0/0", v, count_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_full_stop();
    test_wrap();
    test_cycle_limit();
    test_proto_ts();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_trace_monitor.md
# bus_trace_monitor

Synthesizable, parametrised CPU bus tracer. Sits beside the CPU on ADDRBUS/CTRLBUS/DATABUS and records each bus transaction into an on-chip trace FIFO. The bench or a debug host drains the FIFO through a pop port. A built-in cycle limit ends a capture run, which replaces the bench's fixed-time finish with a hardware "done" indication.

## Interface
- ADDR_W, 16, address bus width
- DATA_W, 16, data bus width
- DEPTH, 64, FIFO entries; power of two, at least 4
- TS_W, 20, timestamp width
- CYCLE_LIMIT, 500000, capture-run length in cycles; 0 disables the limit
- WRAP, 0, 0 = stop when full, 1 = overwrite the oldest entry
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ADDRBUS  in  ADDR_W  CPU address bus
- CTRLBUS  in  2  00 none, 01 read, 10 write, 11 reserved
- DATABUS  in  DATA_W  CPU data bus
- arm  in  1  pulse; starts a capture run
- abort  in  1  pulse; ends a run immediately
- rd_en  in  1  pop request
- rd_valid  out  1  rd_data holds a popped entry
- rd_data  out  TS_W+2+ADDR_W+DATA_W  {ts, ctrl, addr, data}
- count  out  clog2(DEPTH)+1  current occupancy
- empty, full  out  1  FIFO status
- overflow  out  1  sticky; an entry was dropped
- proto_err  out  1  sticky; CTRLBUS=11 was seen
- timeout  out  1  sticky; the run ended on CYCLE_LIMIT
- done  out  1  the monitor is in DONE

## Operation
- States are IDLE, CAPTURE and DONE. Reset state is IDLE.
- Transitions:
  - IDLE to CAPTURE on arm.
  - CAPTURE to DONE on abort, on cycle counter = CYCLE_LIMIT-1 (sets timeout), or when full with WRAP=0 and a push is attempted (sets overflow; that entry is dropped).
  - DONE to CAPTURE on arm.
  - abort in IDLE or DONE does nothing.
- arm clears overflow, proto_err, timeout, the cycle counter and the FIFO. Entries left over from an earlier run are discarded.
- Transaction start: in CAPTURE, a push happens when CTRLBUS≠00 and either (CTRLBUS, ADDRBUS) differs from the previous cycle's value or the previous cycle's CTRLBUS was 00. A multi-cycle read or write with stable address produces exactly one entry.
- CTRLBUS=11 sets proto_err and is captured with ctrl=11.
- Entry fields are the timestamp and the current-cycle CTRLBUS, ADDRBUS and DATABUS.
- The timestamp is the cycle counter. It wraps modulo 2^TS_W. The limit compare uses a separate counter that is at least 32 bits wide.
- WRAP=1, push while full without a pop: the oldest entry is discarded, overflow is set, and count stays at DEPTH.
- Push and pop together while full: no drop, count unchanged.
- Push and pop together while empty: the pop returns nothing, the push is stored, and count becomes 1.
- Pops are allowed in every state. Pushes happen only in CAPTURE.
- Pop with empty=1: rd_valid=0 on the next cycle and no state change.

## Timing
- Push: count, empty and full update on the edge following the sampled transaction.
- Pop latency is 1 cycle. rd_en sampled high at edge N with empty=0 gives rd_valid=1 and rd_data set after edge N+1. rd_valid is a single-cycle pulse per pop. rd_data holds its value until the next pop.
- done asserts on the edge where the terminating condition is sampled. The terminating cycle's own transaction is still captured, except when the run ends because the FIFO is full.
- arm has priority over abort when both occur in the same cycle.
- Reset values: rd_valid=0, rd_data=0, count=0, empty=1, full=0, overflow=0, proto_err=0, timeout=0, done=0.
- Reset mid-run clears everything immediately and discards FIFO contents.

## Configuration
- BUS_TRACE_TIMESTAMP_EN defined: the cycle counter drives the ts field.
- BUS_TRACE_TIMESTAMP_EN not defined: ts is tied to 0 and the timestamp register is not built. rd_data width is unchanged. The CYCLE_LIMIT counter is always present.

## Test plan
- Test 1: reset, then arm, then CTRLBUS=10 with ADDR=0x0100 and DATA=0xBEEF held for 3 cycles, then back to 00.
  - Required: count=1, and a pop returns ctrl=10, addr=0x0100, data=0xBEEF.
- Test 2: WRAP=0, DEPTH=4, then 5 reads to addresses 0..4.
  - Required: full=1, done=1 and overflow=1; pops return addr 0,1,2,3 and then empty=1.
- Test 3: WRAP=1, DEPTH=4, then 6 reads to addresses 0..5.
  - Required: done=0 and overflow=1; pops return addr 2,3,4,5.
- Test 4: CYCLE_LIMIT=100, then arm and leave the bus idle.
  - Required: done=1 and timeout=1 exactly 100 cycles after arm; a re-arm clears both.
- Test 5: with BUS_TRACE_TIMESTAMP_EN defined, CTRLBUS=11 at cycle 7 after arm.
  - Required: proto_err=1, and the entry has ctrl=11 and ts=7.
- Test 6: reset asserted mid-run with count=3.
  - Required: all outputs return to their reset values asynchronously, and a later pop gives rd_valid=0.
